exe_div: RTL and testbench

Multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the execute stage, directly downstream of the ID/EXE pipeline register. It takes the operands, destination register and funct3 that the execute stage pulls from that register. While the divider works it holds a stall request to ctrl, then returns a single-cycle result pulse for write-back.

---
 rtl/exe_div.sv | 174 +++++++++++++++++
 tb/tb_exe_div.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/exe_div.sv
// rtl/exe_div.sv - multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU
// Optional feature macro: DIV_FAST_SPECIAL_EN (divide-by-zero and signed
// overflow finish via START->END in two cycles instead of the full CALC pass).
module exe_div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ready_o,
  output logic [4:0]        reg_waddr_o,
  output logic              busy_o,
  output logic              stall_req_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_CALC  = 2'd2,
    S_END   = 2'd3
  } state_t;

  state_t            r_state;
  logic [1:0]        r_op;
  logic [4:0]        r_waddr_cap;
  logic [DATA_W-1:0] r_dividend;
  logic [DATA_W-1:0] r_divisor;
  logic [DATA_W-1:0] r_dvsr;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quot;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [DATA_W-1:0] r_result;
  logic              r_ready;
  logic [4:0]        r_waddr_o;

  // Operand signs only matter for the signed ops (op[0] == 0).
  logic              w_sign_a;
  logic              w_sign_b;
  logic [DATA_W-1:0] w_abs_a;
  logic [DATA_W-1:0] w_abs_b;
  logic              w_div_nz;

  assign w_sign_a = r_dividend[DATA_W-1] & ~r_op[0];
  assign w_sign_b = r_divisor[DATA_W-1] & ~r_op[0];
  assign w_abs_a  = w_sign_a ? (~r_dividend + 1'b1) : r_dividend;
  assign w_abs_b  = w_sign_b ? (~r_divisor + 1'b1) : r_divisor;
  assign w_div_nz = |r_divisor;

  // One restoring step: the trial difference is one bit wider than the
  // operands so its MSB is the borrow that decides the quotient bit.
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_trial;
  logic [DATA_W-1:0] w_q_nxt;
  logic [DATA_W-1:0] w_r_nxt;
  logic [DATA_W-1:0] w_q_fix;
  logic [DATA_W-1:0] w_r_fix;
  logic              w_last;

  assign w_shift = {r_rem, r_quot[DATA_W-1]};
  assign w_trial = w_shift - {1'b0, r_dvsr};
  assign w_q_nxt = {r_quot[DATA_W-2:0], ~w_trial[DATA_W]};
  assign w_r_nxt = w_trial[DATA_W] ? w_shift[DATA_W-1:0] : w_trial[DATA_W-1:0];
  assign w_q_fix = r_neg_q ? (~w_q_nxt + 1'b1) : w_q_nxt;
  assign w_r_fix = r_neg_r ? (~w_r_nxt + 1'b1) : w_r_nxt;
  assign w_last  = (r_cnt == CNT_W'(DATA_W - 1));

`ifdef DIV_FAST_SPECIAL_EN
  // Short-circuit results for the two cases RISC-V defines explicitly.
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_special;
  logic [DATA_W-1:0] w_sp_quot;
  logic [DATA_W-1:0] w_sp_rem;

  assign w_div_zero = ~w_div_nz;
  assign w_ovf      = ~r_op[0] & (r_dividend == {1'b1, {(DATA_W-1){1'b0}}}) & (&r_divisor);
  assign w_special  = w_div_zero | w_ovf;
  assign w_sp_quot  = w_div_zero ? {DATA_W{1'b1}} : r_dividend;
  assign w_sp_rem   = w_div_zero ? r_dividend : {DATA_W{1'b0}};
`endif

  // Divider FSM: capture, setup, iterate, then publish a one-cycle result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_waddr_cap <= 5'd0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_dvsr      <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_result    <= '0;
      r_ready     <= 1'b0;
      r_waddr_o   <= 5'd0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            r_op        <= op_i;
            r_waddr_cap <= reg_waddr_i;
            r_dividend  <= dividend_i;
            r_divisor   <= divisor_i;
            r_state     <= S_START;
          end
        end
        S_START: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_rem   <= '0;
            r_quot  <= w_abs_a;
            r_dvsr  <= w_abs_b;
            r_cnt   <= '0;
            // A zero divisor leaves the all-ones quotient unsigned-looking.
            r_neg_q <= (w_sign_a ^ w_sign_b) & w_div_nz;
            r_neg_r <= w_sign_a;
`ifdef DIV_FAST_SPECIAL_EN
            if (w_special) begin
              r_result  <= r_op[1] ? w_sp_rem : w_sp_quot;
              r_ready   <= 1'b1;
              r_waddr_o <= r_waddr_cap;
              r_state   <= S_END;
            end else begin
              r_state <= S_CALC;
            end
`else
            r_state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_rem  <= w_r_nxt;
            r_quot <= w_q_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
              r_result  <= r_op[1] ? w_r_fix : w_q_fix;
              r_ready   <= 1'b1;
              r_waddr_o <= r_waddr_cap;
              r_state   <= S_END;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign result_o    = r_result;
  assign ready_o     = r_ready & ~flush_i;
  assign reg_waddr_o = r_waddr_o;
  assign busy_o      = (r_state != S_IDLE);
  assign stall_req_o = ((r_state == S_IDLE) & start_i & ~flush_i) |
                       (r_state == S_START) | (r_state == S_CALC);

endmodule

// File: tb/tb_exe_div.sv
// tb/tb_exe_div.sv - randomized self-checking bench for exe_div
module tb_exe_div;

  logic        clk_i;
  logic        rst_n_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic [4:0]  reg_waddr_o;
  logic        busy_o;
  logic        stall_req_o;

  int          n_checks;
  int          n_errors;
  logic [31:0] last_result;

  exe_div #(.DATA_W(32), .CNT_W(6)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .reg_waddr_i (reg_waddr_i),
    .flush_i     (flush_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .reg_waddr_o (reg_waddr_o),
    .busy_o      (busy_o),
    .stall_req_o (stall_req_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!op[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // Issue one operation from a mid-cycle IDLE point and check its completion.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    int   lat;
    int   exp_lat;
    logic special;
    special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_FAST_SPECIAL_EN
    exp_lat = special ? 2 : 34;
`else
    exp_lat = 34;
`endif
    start_i     = 1'b1;
    op_i        = op;
    dividend_i  = a;
    divisor_i   = b;
    reg_waddr_i = rd;
    #1;
    check_eq("stall_on_start", {31'd0, stall_req_o}, 32'd1);
    @(posedge clk_i);
    #1;
    start_i     = 1'b0;
    op_i        = 2'($urandom);
    dividend_i  = $urandom;
    divisor_i   = $urandom;
    reg_waddr_i = 5'($urandom);
    lat = 1;
    while (!ready_o && lat < 100) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    check_eq($sformatf("ready op%0d %h/%h", op, a, b), {31'd0, ready_o}, 32'd1);
    check_eq($sformatf("result op%0d %h/%h", op, a, b), result_o, exp);
    check_eq("waddr", {27'd0, reg_waddr_o}, {27'd0, rd});
    check_eq($sformatf("latency op%0d %h/%h", op, a, b), lat, exp_lat);
    check_eq("stall_in_end", {31'd0, stall_req_o}, 32'd0);
    last_result = exp;
    @(posedge clk_i);
    #1;
    check_eq("ready_pulse", {31'd0, ready_o}, 32'd0);
    check_eq("idle_after_end", {31'd0, busy_o}, 32'd0);
    check_eq("result_hold", result_o, exp);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          saw_ready;
    n_checks    = 0;
    n_errors    = 0;
    last_result = 32'd0;
    rst_n_i     = 1'b0;
    start_i     = 1'b0;
    op_i        = 2'd0;
    dividend_i  = 32'd0;
    divisor_i   = 32'd0;
    reg_waddr_i = 5'd0;
    flush_i     = 1'b0;

    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_result", result_o, 32'd0);
    check_eq("rst_ready", {31'd0, ready_o}, 32'd0);
    check_eq("rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_stall", {31'd0, stall_req_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    run_op(2'd1, 32'd100, 32'd7, 5'd5, 32'd14);
    run_op(2'd3, 32'd100, 32'd7, 5'd6, 32'd2);
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF);
    run_op(2'd0, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFD);
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'd1);
    run_op(2'd0, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF);
    run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFB);
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0);
    run_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0);
    run_op(2'd3, 32'd5, 32'd0, 5'd16, 32'd5);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 50);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        3:       b = 32'd0 - 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(op, a, b, 5'($urandom), ref_div(op, a, b));
    end

    // Flush in the 10th CALC cycle.
    start_i     = 1'b1;
    op_i        = 2'd1;
    dividend_i  = 32'd1000;
    divisor_i   = 32'd3;
    reg_waddr_i = 5'd20;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (10) begin
      @(posedge clk_i);
      #1;
    end
    check_eq("busy_before_flush", {31'd0, busy_o}, 32'd1);
    check_eq("stall_before_flush", {31'd0, stall_req_o}, 32'd1);
    flush_i = 1'b1;
    #1;
    check_eq("ready_in_flush", {31'd0, ready_o}, 32'd0);
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    check_eq("busy_after_flush", {31'd0, busy_o}, 32'd0);
    check_eq("stall_after_flush", {31'd0, stall_req_o}, 32'd0);
    check_eq("ready_after_flush", {31'd0, ready_o}, 32'd0);
    check_eq("result_kept_flush", result_o, last_result);
    run_op(2'd1, 32'd1000, 32'd3, 5'd21, 32'd333);

    // Asynchronous reset in the middle of CALC.
    start_i     = 1'b1;
    op_i        = 2'd0;
    dividend_i  = 32'd12345;
    divisor_i   = 32'd17;
    reg_waddr_i = 5'd22;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (15) begin
      @(posedge clk_i);
      #1;
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    check_eq("amid_rst_result", result_o, 32'd0);
    check_eq("amid_rst_ready", {31'd0, ready_o}, 32'd0);
    check_eq("amid_rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
    check_eq("amid_rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("amid_rst_stall", {31'd0, stall_req_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i   = 1'b1;
    saw_ready = 0;
    repeat (40) begin
      @(posedge clk_i);
      #1;
      if (ready_o) saw_ready = 1;
    end
    check_eq("no_ready_after_rst", saw_ready, 0);
    run_op(2'd2, 32'd12345, 32'd17, 5'd23, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
